// File: rtl/pix_stream_tx.sv
// Camera-style pixel stream generator (p, lv, fv) fed from a valid/ready byte source.
// Optional PIX_STREAM_TX_TEST_PATTERN_EN adds pattern_sel for a (col + row) test pattern.
module pix_stream_tx #(
    parameter int unsigned COLS   = 640,
    parameter int unsigned ROWS   = 480,
    parameter int unsigned HBLANK = 16,
    parameter int unsigned VPRE   = 4,
    parameter int unsigned VPOST  = 4,
    parameter int unsigned VBLANK = 32
) (
    input  logic        c,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
`ifdef PIX_STREAM_TX_TEST_PATTERN_EN
    input  logic        pattern_sel,
`endif
    output logic        in_ready,
    output logic [7:0]  p,
    output logic        lv,
    output logic        fv,
    output logic [9:0]  row,
    output logic [10:0] col,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        underflow
);

    localparam logic [15:0] VpreLast   = 16'(VPRE - 1);
    localparam logic [15:0] HblankLast = 16'(HBLANK - 1);
    localparam logic [15:0] VpostLast  = 16'(VPOST - 1);
    localparam logic [15:0] VblankLast = 16'(VBLANK - 1);
    localparam logic [10:0] ColLast    = 11'(COLS - 1);
    localparam logic [9:0]  RowLast    = 10'(ROWS - 1);

    typedef enum logic [2:0] {StIdle, StVpre, StLine, StHbl, StVpost, StVbl} state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [7:0]  pix_next;

`ifdef PIX_STREAM_TX_TEST_PATTERN_EN
    logic        pat_q;
    logic [10:0] next_col;
    logic [9:0]  next_row;
`endif

    // in_ready looks one cycle ahead: high exactly when the next cycle is an active pixel.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StVpre:  in_ready = (cnt_q == VpreLast);
            StHbl:   in_ready = (cnt_q == HblankLast);
            StLine:  in_ready = (col != ColLast);
            default: in_ready = 1'b0;
        endcase
`ifdef PIX_STREAM_TX_TEST_PATTERN_EN
        if (pat_q) in_ready = 1'b0;
`endif
    end

    always_comb begin
        pix_next = in_valid ? in_data : 8'h00;
`ifdef PIX_STREAM_TX_TEST_PATTERN_EN
        next_col = (state_q == StLine) ? col + 11'd1 : 11'd0;
        next_row = (state_q == StHbl) ? row + 10'd1 : row;
        if (pat_q) pix_next = next_col[7:0] + next_row[7:0];
`endif
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            p          <= '0;
            lv         <= 1'b0;
            fv         <= 1'b0;
            row        <= '0;
            col        <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            underflow  <= 1'b0;
`ifdef PIX_STREAM_TX_TEST_PATTERN_EN
            pat_q      <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (in_ready && !in_valid) underflow <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        state_q <= StVpre;
                        fv      <= 1'b1;
                        row     <= '0;
                        cnt_q   <= '0;
`ifdef PIX_STREAM_TX_TEST_PATTERN_EN
                        pat_q   <= pattern_sel;
`endif
                    end
                end
                StVpre: begin
                    if (cnt_q == VpreLast) begin
                        state_q <= StLine;
                        lv      <= 1'b1;
                        col     <= '0;
                        p       <= pix_next;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StLine: begin
                    if (col == ColLast) begin
                        lv      <= 1'b0;
                        col     <= '0;
                        p       <= '0;
                        cnt_q   <= '0;
                        state_q <= (row == RowLast) ? StVpost : StHbl;
                    end else begin
                        col <= col + 11'd1;
                        p   <= pix_next;
                    end
                end
                StHbl: begin
                    if (cnt_q == HblankLast) begin
                        state_q <= StLine;
                        lv      <= 1'b1;
                        row     <= row + 10'd1;
                        p       <= pix_next;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StVpost: begin
                    if (cnt_q == VpostLast) begin
                        state_q    <= StVbl;
                        fv         <= 1'b0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StVbl: begin
                    if (cnt_q == VblankLast) begin
                        cnt_q <= '0;
                        if (en) begin
                            state_q <= StVpre;
                            fv      <= 1'b1;
                            row     <= '0;
`ifdef PIX_STREAM_TX_TEST_PATTERN_EN
                            pat_q   <= pattern_sel;
`endif
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pix_stream_tx.sv
// Directed bench for pix_stream_tx with COLS=4, ROWS=2, HBLANK=8, VPRE=2, VPOST=3, VBLANK=5.
module tb_pix_stream_tx;

    logic        c = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [7:0]  p;
    logic        lv;
    logic        fv;
    logic [9:0]  row;
    logic [10:0] col;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        underflow;
`ifdef PIX_STREAM_TX_TEST_PATTERN_EN
    logic        pattern_sel = 1'b0;
`endif

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    pix_stream_tx #(
        .COLS(4), .ROWS(2), .HBLANK(8), .VPRE(2), .VPOST(3), .VBLANK(5)
    ) dut (
        .c(c),
        .rst(rst),
        .en(en),
        .in_valid(in_valid),
        .in_data(in_data),
`ifdef PIX_STREAM_TX_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .in_ready(in_ready),
        .p(p),
        .lv(lv),
        .fv(fv),
        .row(row),
        .col(col),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt),
        .underflow(underflow)
    );

    always #5 c = ~c;

    function automatic logic [31:0] pk(logic f, logic l, logic d, logic [9:0] r,
                                       logic [10:0] cc, logic [7:0] pp);
        return {f, l, d, r, cc, pp};
    endfunction

    function automatic logic [31:0] stream();
        return pk(fv, lv, frame_done, row, col, p);
    endfunction

    // Cycle offset j within a frame (j=0: cycle en/end-of-VBL is sampled).
    function automatic bit lv_at(int j);
        return (j >= 3 && j <= 6) || (j >= 15 && j <= 18);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Upstream model: the byte advances only on an accepted handshake.
    task automatic tick();
        logic fire;
        fire = in_valid && in_ready;
        @(posedge c);
        #1;
        if (fire) in_data = in_data + 8'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input logic [9:0] row_e);
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("idle%0d", i), stream(), pk(1'b0, 1'b0, 1'b0, row_e, 11'd0, 8'd0));
        end
    endtask

    // One full frame starting at the cycle where en is sampled; drop_k withholds in_valid.
    task automatic run_frame(input logic [7:0] base, input int drop_k, input int en_off_k,
                             input bit pat);
        int j, n, d;
        logic f_e, l_e, d_e;
        logic [9:0]  r_e;
        logic [10:0] c_e;
        logic [7:0]  p_e;
        d = -1;
        if (drop_k >= 2 && drop_k <= 5) d = drop_k - 2;
        if (drop_k >= 14 && drop_k <= 17) d = drop_k - 10;
        for (int k = 0; k < 26; k++) begin
            if (k == en_off_k) en = 1'b0;
            in_valid = (k != drop_k);
            check($sformatf("in_ready k%0d", k), {31'd0, in_ready},
                  {31'd0, (lv_at(k + 1) && !pat)});
            tick();
            j   = k + 1;
            f_e = (j <= 21);
            l_e = lv_at(j);
            d_e = (j == 22);
            r_e = (j >= 15) ? 10'd1 : 10'd0;
            n   = (j <= 6) ? j - 3 : j - 11;
            c_e = l_e ? 11'(n % 4) : 11'd0;
            if (!l_e) p_e = 8'h00;
            else if (pat) p_e = 8'(c_e) + 8'(r_e);
            else if (d < 0 || n < d) p_e = base + 8'(n);
            else if (n == d) p_e = 8'h00;
            else p_e = base + 8'(n - 1);
            check($sformatf("stream j%0d", j), stream(), pk(f_e, l_e, d_e, r_e, c_e, p_e));
        end
    endtask

    initial begin
        do_reset();
        check("reset stream", stream(), 32'd0);
        check("reset frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("reset underflow", {31'd0, underflow}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd0);

        // Single frame, data 0x10 upward.
        in_data = 8'h10;
        en = 1'b1;
        run_frame(8'h10, -1, 1, 1'b0);
        check("t1 frame_cnt", {16'd0, frame_cnt}, 32'd1);
        check("t1 underflow", {31'd0, underflow}, 32'd0);
        idle_cycles(3, 10'd1);

        // en dropped on the second cycle of line 1: frame still completes.
        en = 1'b1;
        run_frame(in_data, -1, 16, 1'b0);
        check("t4 frame_cnt", {16'd0, frame_cnt}, 32'd2);
        idle_cycles(10, 10'd1);

        // Three back-to-back frames with en held.
        do_reset();
        check("t2 reset frame_cnt", {16'd0, frame_cnt}, 32'd0);
        en = 1'b1;
        run_frame(in_data, -1, -1, 1'b0);
        run_frame(in_data, -1, -1, 1'b0);
        run_frame(in_data, -1, 1, 1'b0);
        check("t2 frame_cnt", {16'd0, frame_cnt}, 32'd3);
        idle_cycles(2, 10'd1);

        // Underflow on the third ready cycle of line 0.
        do_reset();
        in_data = 8'h10;
        en = 1'b1;
        run_frame(8'h10, 4, 1, 1'b0);
        check("t3 underflow", {31'd0, underflow}, 32'd1);
        idle_cycles(5, 10'd1);
        check("t3 underflow sticky", {31'd0, underflow}, 32'd1);
        do_reset();
        check("t3 underflow cleared", {31'd0, underflow}, 32'd0);

        // Reset mid-line; underflow first set by withholding the first pixel.
        in_data = 8'h40;
        en = 1'b1;
        in_valid = 1'b1;
        tick();
        en = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        check("t5 underflow set", {31'd0, underflow}, 32'd1);
        check("t5 first pixel", stream(), pk(1'b1, 1'b1, 1'b0, 10'd0, 11'd0, 8'h00));
        tick();
        tick();
        check("t5 col2", stream(), pk(1'b1, 1'b1, 1'b0, 10'd0, 11'd2, 8'h41));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5 after rst stream", stream(), 32'd0);
        check("t5 after rst underflow", {31'd0, underflow}, 32'd0);
        check("t5 after rst frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("t5 after rst in_ready", {31'd0, in_ready}, 32'd0);
        en = 1'b1;
        run_frame(in_data, -1, 1, 1'b0);
        check("t5 frame_cnt", {16'd0, frame_cnt}, 32'd1);

`ifdef PIX_STREAM_TX_TEST_PATTERN_EN
        do_reset();
        pattern_sel = 1'b1;
        en = 1'b1;
        run_frame(8'h00, -1, 1, 1'b1);
        pattern_sel = 1'b0;
        check("t6 underflow", {31'd0, underflow}, 32'd0);
        check("t6 frame_cnt", {16'd0, frame_cnt}, 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
